axi_wide_to_narrow: RTL and testbench



---
 rtl/axi_wide_to_narrow.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_axi_wide_to_narrow.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wide_to_narrow.sv
// AXI width down-converter: splits wide upstream transfers into narrow
// downstream beats and packs narrow read beats back into wide beats.
// One outstanding transaction per direction.
module axi_wide_to_narrow #(
    parameter int unsigned SOURCE_WIDTH = 128,
    parameter int unsigned TARGET_WIDTH = 64
) (
    input  logic                      aclk,
    input  logic                      areset,
    // upstream write address
    input  logic [31:0]               u_axi_awaddr,
    input  logic [2:0]                u_axi_awsize,
    input  logic [7:0]                u_axi_awlen,
    input  logic [1:0]                u_axi_awburst,
    input  logic                      u_axi_awvalid,
    output logic                      u_axi_awready,
    // upstream write data
    input  logic [SOURCE_WIDTH-1:0]   u_axi_wdata,
    input  logic [SOURCE_WIDTH/8-1:0] u_axi_wstrb,
    input  logic                      u_axi_wlast,
    input  logic                      u_axi_wvalid,
    output logic                      u_axi_wready,
    // upstream write response
    output logic [1:0]                u_axi_bresp,
    output logic                      u_axi_bvalid,
    input  logic                      u_axi_bready,
    // upstream read address
    input  logic [31:0]               u_axi_araddr,
    input  logic [2:0]                u_axi_arsize,
    input  logic [7:0]                u_axi_arlen,
    input  logic [1:0]                u_axi_arburst,
    input  logic                      u_axi_arvalid,
    output logic                      u_axi_arready,
    // upstream read data
    output logic [SOURCE_WIDTH-1:0]   u_axi_rdata,
    output logic [1:0]                u_axi_rresp,
    output logic                      u_axi_rlast,
    output logic                      u_axi_rvalid,
    input  logic                      u_axi_rready,
    // downstream write address
    output logic [31:0]               d_axi_awaddr,
    output logic [2:0]                d_axi_awsize,
    output logic [7:0]                d_axi_awlen,
    output logic [1:0]                d_axi_awburst,
    output logic                      d_axi_awvalid,
    input  logic                      d_axi_awready,
    // downstream write data
    output logic [TARGET_WIDTH-1:0]   d_axi_wdata,
    output logic [TARGET_WIDTH/8-1:0] d_axi_wstrb,
    output logic                      d_axi_wlast,
    output logic                      d_axi_wvalid,
    input  logic                      d_axi_wready,
    // downstream write response
    input  logic [1:0]                d_axi_bresp,
    input  logic                      d_axi_bvalid,
    output logic                      d_axi_bready,
    // downstream read address
    output logic [31:0]               d_axi_araddr,
    output logic [2:0]                d_axi_arsize,
    output logic [7:0]                d_axi_arlen,
    output logic [1:0]                d_axi_arburst,
    output logic                      d_axi_arvalid,
    input  logic                      d_axi_arready,
    // downstream read data
    input  logic [TARGET_WIDTH-1:0]   d_axi_rdata,
    input  logic [1:0]                d_axi_rresp,
    input  logic                      d_axi_rlast,
    input  logic                      d_axi_rvalid,
    output logic                      d_axi_rready
);

    localparam int unsigned SOURCE_BYTES     = SOURCE_WIDTH / 8;
    localparam int unsigned TARGET_BYTES     = TARGET_WIDTH / 8;
    localparam int unsigned SOURCE_ADDR_BITS = $clog2(SOURCE_BYTES);
    localparam int unsigned TARGET_ADDR_BITS = $clog2(TARGET_BYTES);
    localparam int unsigned LANE_BITS        = SOURCE_ADDR_BITS - TARGET_ADDR_BITS;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // log2 of the split ratio; 0 means the transfer passes beat-for-beat
    function automatic logic [2:0] ratio_log2(input logic [2:0] size);
        logic [2:0] rl;
        rl = 3'd0;
        if (32'(size) > TARGET_ADDR_BITS) rl = 3'(32'(size) - TARGET_ADDR_BITS);
        return rl;
    endfunction

    // downstream burst length after splitting; truncated to 8 bits
    function automatic logic [7:0] scaled_len(input logic [7:0] len, input logic [2:0] rl);
        return 8'(((32'(len) + 32'd1) << rl) - 32'd1);
    endfunction

    // address of the next downstream beat
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst,
                                              input logic split);
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] res;
        step = 32'd1 << size;
        mask = ((32'(len) + 32'd1) << size) - 32'd1;
        if (split)                    res = a + 32'(TARGET_BYTES);
        else if (burst == BURST_FIXED) res = a;
        else if (burst == BURST_WRAP)  res = (a & ~mask) | ((a + step) & mask);
        else                          res = a + step;
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    w_state_t             w_state;
    logic [31:0]          w_beat_addr;
    logic [2:0]           w_size;
    logic [7:0]           w_len;
    logic [1:0]           w_burst;
    logic                 w_split;
    logic [7:0]           w_last_sub;
    logic [7:0]           w_sub;
    logic [2:0]           aw_rl;
    logic [LANE_BITS-1:0] w_lane;
    logic                 w_final_sub;

    assign aw_rl       = ratio_log2(u_axi_awsize);
    assign w_lane      = w_beat_addr[SOURCE_ADDR_BITS-1:TARGET_ADDR_BITS];
    assign w_final_sub = (w_sub == w_last_sub);

    assign u_axi_awready = (w_state == W_IDLE) && !areset;
    assign d_axi_awvalid = (w_state == W_ADDR);
    assign d_axi_wvalid  = (w_state == W_DATA) && u_axi_wvalid;
    assign d_axi_wdata   = u_axi_wdata[32'(w_lane)*TARGET_WIDTH +: TARGET_WIDTH];
    assign d_axi_wstrb   = u_axi_wstrb[32'(w_lane)*TARGET_BYTES +: TARGET_BYTES];
    assign d_axi_wlast   = (w_state == W_DATA) && u_axi_wlast && w_final_sub;
    assign u_axi_wready  = (w_state == W_DATA) && d_axi_wready && w_final_sub;
    assign u_axi_bvalid  = (w_state == W_RESP) && d_axi_bvalid;
    assign d_axi_bready  = (w_state == W_RESP) && u_axi_bready;
    assign u_axi_bresp   = d_axi_bresp;

    // write FSM: capture AW, issue downstream AW, stream sub-beats, relay B
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state       <= W_IDLE;
            w_beat_addr   <= '0;
            w_size        <= '0;
            w_len         <= '0;
            w_burst       <= '0;
            w_split       <= 1'b0;
            w_last_sub    <= '0;
            w_sub         <= '0;
            d_axi_awaddr  <= '0;
            d_axi_awsize  <= '0;
            d_axi_awlen   <= '0;
            d_axi_awburst <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (u_axi_awvalid) begin
                        d_axi_awaddr  <= u_axi_awaddr;
                        d_axi_awsize  <= (aw_rl != 3'd0) ? 3'(TARGET_ADDR_BITS) : u_axi_awsize;
                        d_axi_awlen   <= scaled_len(u_axi_awlen, aw_rl);
                        d_axi_awburst <= u_axi_awburst;
                        w_beat_addr   <= u_axi_awaddr;
                        w_size        <= u_axi_awsize;
                        w_len         <= u_axi_awlen;
                        w_burst       <= u_axi_awburst;
                        w_split       <= (aw_rl != 3'd0);
                        w_last_sub    <= 8'((32'd1 << aw_rl) - 32'd1);
                        w_sub         <= '0;
                        w_state       <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (d_axi_awready) w_state <= W_DATA;
                end
                W_DATA: begin
                    if (d_axi_wvalid && d_axi_wready) begin
                        w_beat_addr <= next_addr(w_beat_addr, w_size, w_len, w_burst, w_split);
                        w_sub       <= w_final_sub ? 8'd0 : w_sub + 8'd1;
                        if (d_axi_wlast) w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (d_axi_bvalid && u_axi_bready) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    r_state_t             r_state;
    logic [31:0]          r_beat_addr;
    logic [2:0]           r_size;
    logic [7:0]           r_len;
    logic [1:0]           r_burst;
    logic                 r_split;
    logic [7:0]           r_last_sub;
    logic [7:0]           r_sub;
    logic [SOURCE_WIDTH-1:0] r_buf;
    logic [1:0]           r_resp_acc;
    logic [2:0]           ar_rl;
    logic [LANE_BITS-1:0] r_lane;
    logic                 r_final_sub;
    logic [SOURCE_WIDTH-1:0] r_merged;
    logic [1:0]           r_resp_new;

    assign ar_rl       = ratio_log2(u_axi_arsize);
    assign r_lane      = r_beat_addr[SOURCE_ADDR_BITS-1:TARGET_ADDR_BITS];
    assign r_final_sub = (r_sub == r_last_sub);

    assign u_axi_arready = (r_state == R_IDLE) && !areset;
    assign d_axi_arvalid = (r_state == R_ADDR);
    assign d_axi_rready  = (r_state == R_DATA) && !u_axi_rvalid;

    // pack buffer with the incoming narrow beat merged into its lane
    always_comb begin
        r_merged = r_buf;
        r_merged[32'(r_lane)*TARGET_WIDTH +: TARGET_WIDTH] = d_axi_rdata;
        r_resp_new = (d_axi_rresp > r_resp_acc) ? d_axi_rresp : r_resp_acc;
    end

    // read FSM: capture AR, issue downstream AR, pack beats, hold wide beat
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= R_IDLE;
            r_beat_addr   <= '0;
            r_size        <= '0;
            r_len         <= '0;
            r_burst       <= '0;
            r_split       <= 1'b0;
            r_last_sub    <= '0;
            r_sub         <= '0;
            r_buf         <= '0;
            r_resp_acc    <= '0;
            d_axi_araddr  <= '0;
            d_axi_arsize  <= '0;
            d_axi_arlen   <= '0;
            d_axi_arburst <= '0;
            u_axi_rdata   <= '0;
            u_axi_rresp   <= '0;
            u_axi_rlast   <= 1'b0;
            u_axi_rvalid  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (u_axi_arvalid) begin
                        d_axi_araddr  <= u_axi_araddr;
                        d_axi_arsize  <= (ar_rl != 3'd0) ? 3'(TARGET_ADDR_BITS) : u_axi_arsize;
                        d_axi_arlen   <= scaled_len(u_axi_arlen, ar_rl);
                        d_axi_arburst <= u_axi_arburst;
                        r_beat_addr   <= u_axi_araddr;
                        r_size        <= u_axi_arsize;
                        r_len         <= u_axi_arlen;
                        r_burst       <= u_axi_arburst;
                        r_split       <= (ar_rl != 3'd0);
                        r_last_sub    <= 8'((32'd1 << ar_rl) - 32'd1);
                        r_sub         <= '0;
                        r_state       <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (d_axi_arready) r_state <= R_DATA;
                end
                R_DATA: begin
                    if (u_axi_rvalid) begin
                        if (u_axi_rready) begin
                            u_axi_rvalid <= 1'b0;
                            r_buf        <= '0;
                            r_resp_acc   <= '0;
                            if (u_axi_rlast) r_state <= R_IDLE;
                        end
                    end else if (d_axi_rvalid) begin
                        r_buf       <= r_merged;
                        r_resp_acc  <= r_resp_new;
                        r_beat_addr <= next_addr(r_beat_addr, r_size, r_len, r_burst, r_split);
                        r_sub       <= r_final_sub ? 8'd0 : r_sub + 8'd1;
                        if (r_final_sub) begin
                            u_axi_rvalid <= 1'b1;
                            u_axi_rdata  <= r_merged;
                            u_axi_rresp  <= r_resp_new;
                            u_axi_rlast  <= d_axi_rlast;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    task automatic check_request(input string dir, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [7:0] len,
                                 input logic [1:0] burst);
        logic [2:0] rl;
        rl = ratio_log2(size);
        if (32'(size) > SOURCE_ADDR_BITS)
            $error("%s size %0d exceeds upstream width", dir, size);
        if ((addr & ((32'd1 << size) - 32'd1)) != 32'd0)
            $error("%s address %h unaligned to size %0d", dir, addr, size);
        if (((32'(len) + 32'd1) << rl) > 32'd256)
            $error("%s split burst too long, len %0d size %0d", dir, len, size);
        if (rl != 3'd0 && burst != BURST_INCR)
            $error("%s split of non-INCR burst %0d handled as INCR", dir, burst);
    endtask

    // flag illegal upstream requests at acceptance
    always @(posedge aclk) begin
        if (!areset && u_axi_awvalid && u_axi_awready)
            check_request("AW", u_axi_awaddr, u_axi_awsize, u_axi_awlen, u_axi_awburst);
        if (!areset && u_axi_arvalid && u_axi_arready)
            check_request("AR", u_axi_araddr, u_axi_arsize, u_axi_arlen, u_axi_arburst);
    end
`endif

endmodule

// File: tb/tb_axi_wide_to_narrow.sv
// Directed bench for axi_wide_to_narrow (128-bit upstream, 64-bit downstream).
module tb_axi_wide_to_narrow;

    logic         aclk;
    logic         areset;
    logic [31:0]  u_axi_awaddr;
    logic [2:0]   u_axi_awsize;
    logic [7:0]   u_axi_awlen;
    logic [1:0]   u_axi_awburst;
    logic         u_axi_awvalid;
    logic         u_axi_awready;
    logic [127:0] u_axi_wdata;
    logic [15:0]  u_axi_wstrb;
    logic         u_axi_wlast;
    logic         u_axi_wvalid;
    logic         u_axi_wready;
    logic [1:0]   u_axi_bresp;
    logic         u_axi_bvalid;
    logic         u_axi_bready;
    logic [31:0]  u_axi_araddr;
    logic [2:0]   u_axi_arsize;
    logic [7:0]   u_axi_arlen;
    logic [1:0]   u_axi_arburst;
    logic         u_axi_arvalid;
    logic         u_axi_arready;
    logic [127:0] u_axi_rdata;
    logic [1:0]   u_axi_rresp;
    logic         u_axi_rlast;
    logic         u_axi_rvalid;
    logic         u_axi_rready;
    logic [31:0]  d_axi_awaddr;
    logic [2:0]   d_axi_awsize;
    logic [7:0]   d_axi_awlen;
    logic [1:0]   d_axi_awburst;
    logic         d_axi_awvalid;
    logic         d_axi_awready;
    logic [63:0]  d_axi_wdata;
    logic [7:0]   d_axi_wstrb;
    logic         d_axi_wlast;
    logic         d_axi_wvalid;
    logic         d_axi_wready;
    logic [1:0]   d_axi_bresp;
    logic         d_axi_bvalid;
    logic         d_axi_bready;
    logic [31:0]  d_axi_araddr;
    logic [2:0]   d_axi_arsize;
    logic [7:0]   d_axi_arlen;
    logic [1:0]   d_axi_arburst;
    logic         d_axi_arvalid;
    logic         d_axi_arready;
    logic [63:0]  d_axi_rdata;
    logic [1:0]   d_axi_rresp;
    logic         d_axi_rlast;
    logic         d_axi_rvalid;
    logic         d_axi_rready;

    int errors = 0;
    int checks = 0;

    axi_wide_to_narrow #(.SOURCE_WIDTH(128), .TARGET_WIDTH(64)) dut (
        .aclk(aclk), .areset(areset),
        .u_axi_awaddr(u_axi_awaddr), .u_axi_awsize(u_axi_awsize), .u_axi_awlen(u_axi_awlen),
        .u_axi_awburst(u_axi_awburst), .u_axi_awvalid(u_axi_awvalid), .u_axi_awready(u_axi_awready),
        .u_axi_wdata(u_axi_wdata), .u_axi_wstrb(u_axi_wstrb), .u_axi_wlast(u_axi_wlast),
        .u_axi_wvalid(u_axi_wvalid), .u_axi_wready(u_axi_wready),
        .u_axi_bresp(u_axi_bresp), .u_axi_bvalid(u_axi_bvalid), .u_axi_bready(u_axi_bready),
        .u_axi_araddr(u_axi_araddr), .u_axi_arsize(u_axi_arsize), .u_axi_arlen(u_axi_arlen),
        .u_axi_arburst(u_axi_arburst), .u_axi_arvalid(u_axi_arvalid), .u_axi_arready(u_axi_arready),
        .u_axi_rdata(u_axi_rdata), .u_axi_rresp(u_axi_rresp), .u_axi_rlast(u_axi_rlast),
        .u_axi_rvalid(u_axi_rvalid), .u_axi_rready(u_axi_rready),
        .d_axi_awaddr(d_axi_awaddr), .d_axi_awsize(d_axi_awsize), .d_axi_awlen(d_axi_awlen),
        .d_axi_awburst(d_axi_awburst), .d_axi_awvalid(d_axi_awvalid), .d_axi_awready(d_axi_awready),
        .d_axi_wdata(d_axi_wdata), .d_axi_wstrb(d_axi_wstrb), .d_axi_wlast(d_axi_wlast),
        .d_axi_wvalid(d_axi_wvalid), .d_axi_wready(d_axi_wready),
        .d_axi_bresp(d_axi_bresp), .d_axi_bvalid(d_axi_bvalid), .d_axi_bready(d_axi_bready),
        .d_axi_araddr(d_axi_araddr), .d_axi_arsize(d_axi_arsize), .d_axi_arlen(d_axi_arlen),
        .d_axi_arburst(d_axi_arburst), .d_axi_arvalid(d_axi_arvalid), .d_axi_arready(d_axi_arready),
        .d_axi_rdata(d_axi_rdata), .d_axi_rresp(d_axi_rresp), .d_axi_rlast(d_axi_rlast),
        .d_axi_rvalid(d_axi_rvalid), .d_axi_rready(d_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [127:0] d0, d1, wd;
    logic [63:0]  exp_split [4];
    logic [15:0]  strb_tab  [4];
    logic [7:0]   strb_exp  [4];
    int           lane_pass [4];
    int           lane_wrap [4];
    logic [63:0]  ra, rb, c0, c1, c2, c3, e0;

    initial begin
        d0 = 128'h0F0E0D0C0B0A0908_0706050403020100;
        d1 = 128'h1F1E1D1C1B1A1918_1716151413121110;
        exp_split = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908,
                      64'h1716151413121110, 64'h1F1E1D1C1B1A1918};
        strb_tab  = '{16'h00F0, 16'h0F00, 16'hF000, 16'h000F};
        strb_exp  = '{8'hF0, 8'h0F, 8'hF0, 8'h0F};
        lane_pass = '{0, 1, 1, 0};
        lane_wrap = '{1, 0, 1, 0};
        ra = 64'hAAAA_0000_1111_2222;
        rb = 64'hBBBB_3333_4444_5555;
        c0 = 64'hC000_0000_0000_0000;
        c1 = 64'hC111_1111_1111_1111;
        c2 = 64'hC222_2222_2222_2222;
        c3 = 64'hC333_3333_3333_3333;
        e0 = 64'hEEEE_EEEE_0000_1234;

        areset = 1'b1;
        u_axi_awaddr = '0; u_axi_awsize = '0; u_axi_awlen = '0; u_axi_awburst = '0; u_axi_awvalid = 0;
        u_axi_wdata = '0; u_axi_wstrb = '0; u_axi_wlast = 0; u_axi_wvalid = 0; u_axi_bready = 0;
        u_axi_araddr = '0; u_axi_arsize = '0; u_axi_arlen = '0; u_axi_arburst = '0; u_axi_arvalid = 0;
        u_axi_rready = 0;
        d_axi_awready = 0; d_axi_wready = 0; d_axi_bresp = '0; d_axi_bvalid = 0; d_axi_arready = 0;
        d_axi_rdata = '0; d_axi_rresp = '0; d_axi_rlast = 0; d_axi_rvalid = 0;

        // reset state
        repeat (3) tick();
        chk("rst_awready", u_axi_awready, 1'b0);
        chk("rst_arready", u_axi_arready, 1'b0);
        chk("rst_d_awvalid", d_axi_awvalid, 1'b0);
        chk("rst_d_arvalid", d_axi_arvalid, 1'b0);
        chk("rst_rvalid", u_axi_rvalid, 1'b0);
        chk("rst_d_wvalid", d_axi_wvalid, 1'b0);
        areset = 1'b0;
        tick();
        chk("post_rst_awready", u_axi_awready, 1'b1);
        chk("post_rst_arready", u_axi_arready, 1'b1);

        // write split: 0x1000 size4 len1 -> size3 len3
        u_axi_awaddr = 32'h1000; u_axi_awsize = 3'd4; u_axi_awlen = 8'd1; u_axi_awburst = 2'b01;
        u_axi_awvalid = 1;
        #1 chk("ws_awready", u_axi_awready, 1'b1);
        tick();
        u_axi_awvalid = 0;
        #1;
        chk("ws_d_awvalid", d_axi_awvalid, 1'b1);
        chk("ws_d_awaddr", d_axi_awaddr, 32'h1000);
        chk("ws_d_awsize", d_axi_awsize, 3'd3);
        chk("ws_d_awlen", d_axi_awlen, 8'd3);
        chk("ws_d_awburst", d_axi_awburst, 2'b01);
        chk("ws_awready_busy", u_axi_awready, 1'b0);
        d_axi_awready = 1;
        tick();
        d_axi_awready = 0;
        for (int i = 0; i < 4; i++) begin
            u_axi_wdata = (i < 2) ? d0 : d1;
            u_axi_wstrb = 16'hFFFF;
            u_axi_wlast = (i >= 2);
            u_axi_wvalid = 1;
            d_axi_wready = 1;
            #1;
            chk("ws_d_wvalid", d_axi_wvalid, 1'b1);
            chk("ws_d_wdata", d_axi_wdata, exp_split[i]);
            chk("ws_d_wstrb", d_axi_wstrb, 8'hFF);
            chk("ws_d_wlast", d_axi_wlast, (i == 3));
            chk("ws_u_wready", u_axi_wready, (i == 1 || i == 3));
            tick();
        end
        u_axi_wvalid = 0; u_axi_wlast = 0; d_axi_wready = 0;
        #1 chk("ws_wvalid_after", d_axi_wvalid, 1'b0);
        // B held by upstream; next AW waits until after the B handshake
        d_axi_bvalid = 1; d_axi_bresp = 2'b00; u_axi_bready = 0;
        u_axi_awaddr = 32'h2004; u_axi_awsize = 3'd2; u_axi_awlen = 8'd3; u_axi_awburst = 2'b01;
        u_axi_awvalid = 1;
        #1;
        chk("ws_bvalid", u_axi_bvalid, 1'b1);
        chk("ws_d_bready_hold", d_axi_bready, 1'b0);
        chk("ws_awready_resp", u_axi_awready, 1'b0);
        tick();
        u_axi_bready = 1;
        #1;
        chk("ws_d_bready", d_axi_bready, 1'b1);
        chk("ws_awready_bhs", u_axi_awready, 1'b0);
        tick();
        d_axi_bvalid = 0; u_axi_bready = 0;
        #1;
        chk("ws_bvalid_done", u_axi_bvalid, 1'b0);
        chk("ws_awready_next", u_axi_awready, 1'b1);
        tick();
        u_axi_awvalid = 0;

        // narrow pass INCR: 0x2004 size2 len3, lanes 0,1,1,0
        #1;
        chk("np_d_awaddr", d_axi_awaddr, 32'h2004);
        chk("np_d_awsize", d_axi_awsize, 3'd2);
        chk("np_d_awlen", d_axi_awlen, 8'd3);
        d_axi_awready = 1;
        tick();
        d_axi_awready = 0;
        for (int i = 0; i < 4; i++) begin
            wd = {64'h2222_2222_0000_0000 + 64'(i), 64'h1111_1111_0000_0000 + 64'(i)};
            u_axi_wdata = wd;
            u_axi_wstrb = strb_tab[i];
            u_axi_wlast = (i == 3);
            u_axi_wvalid = 1;
            d_axi_wready = 1;
            #1;
            chk("np_d_wdata", d_axi_wdata, (lane_pass[i] == 1) ? wd[127:64] : wd[63:0]);
            chk("np_d_wstrb", d_axi_wstrb, strb_exp[i]);
            chk("np_u_wready", u_axi_wready, 1'b1);
            chk("np_d_wlast", d_axi_wlast, (i == 3));
            tick();
        end
        u_axi_wvalid = 0; u_axi_wlast = 0; d_axi_wready = 0;
        d_axi_bvalid = 1; d_axi_bresp = 2'b01; u_axi_bready = 1;
        #1;
        chk("np_bvalid", u_axi_bvalid, 1'b1);
        chk("np_bresp", u_axi_bresp, 2'b01);
        tick();
        d_axi_bvalid = 0; u_axi_bready = 0;

        // pass WRAP: 0x4038 size3 len3, lanes 1,0,1,0
        u_axi_awaddr = 32'h4038; u_axi_awsize = 3'd3; u_axi_awlen = 8'd3; u_axi_awburst = 2'b10;
        u_axi_awvalid = 1;
        tick();
        u_axi_awvalid = 0;
        #1;
        chk("wr_d_awaddr", d_axi_awaddr, 32'h4038);
        chk("wr_d_awsize", d_axi_awsize, 3'd3);
        chk("wr_d_awburst", d_axi_awburst, 2'b10);
        d_axi_awready = 1;
        tick();
        d_axi_awready = 0;
        for (int i = 0; i < 4; i++) begin
            wd = {64'hB0 + 64'(i), 64'hA0 + 64'(i)};
            u_axi_wdata = wd;
            u_axi_wstrb = 16'hFFFF;
            u_axi_wlast = (i == 3);
            u_axi_wvalid = 1;
            d_axi_wready = 1;
            #1;
            chk("wr_d_wdata", d_axi_wdata, (lane_wrap[i] == 1) ? wd[127:64] : wd[63:0]);
            chk("wr_d_wlast", d_axi_wlast, (i == 3));
            tick();
        end
        u_axi_wvalid = 0; u_axi_wlast = 0; d_axi_wready = 0;
        d_axi_bvalid = 1; d_axi_bresp = 2'b00; u_axi_bready = 1;
        tick();
        d_axi_bvalid = 0; u_axi_bready = 0;

        // read split: 0x3000 size4 len0, A OKAY then B SLVERR
        u_axi_araddr = 32'h3000; u_axi_arsize = 3'd4; u_axi_arlen = 8'd0; u_axi_arburst = 2'b01;
        u_axi_arvalid = 1;
        #1 chk("rs_arready", u_axi_arready, 1'b1);
        tick();
        u_axi_arvalid = 0;
        #1;
        chk("rs_d_arvalid", d_axi_arvalid, 1'b1);
        chk("rs_d_araddr", d_axi_araddr, 32'h3000);
        chk("rs_d_arsize", d_axi_arsize, 3'd3);
        chk("rs_d_arlen", d_axi_arlen, 8'd1);
        d_axi_arready = 1;
        tick();
        d_axi_arready = 0;
        #1 chk("rs_d_rready", d_axi_rready, 1'b1);
        d_axi_rvalid = 1; d_axi_rdata = ra; d_axi_rresp = 2'b00; d_axi_rlast = 0;
        tick();
        d_axi_rdata = rb; d_axi_rresp = 2'b10; d_axi_rlast = 1;
        #1 chk("rs_rvalid_early", u_axi_rvalid, 1'b0);
        tick();
        d_axi_rvalid = 0; d_axi_rlast = 0;
        #1;
        chk("rs_rvalid", u_axi_rvalid, 1'b1);
        chk("rs_rdata", u_axi_rdata, {rb, ra});
        chk("rs_rresp", u_axi_rresp, 2'b10);
        chk("rs_rlast", u_axi_rlast, 1'b1);
        u_axi_rready = 1;
        tick();
        u_axi_rready = 0;
        #1;
        chk("rs_rvalid_done", u_axi_rvalid, 1'b0);
        chk("rs_arready_done", u_axi_arready, 1'b1);

        // read backpressure: 0x5000 size4 len1
        u_axi_araddr = 32'h5000; u_axi_arsize = 3'd4; u_axi_arlen = 8'd1; u_axi_arburst = 2'b01;
        u_axi_arvalid = 1;
        tick();
        u_axi_arvalid = 0;
        #1 chk("bp_d_arlen", d_axi_arlen, 8'd3);
        d_axi_arready = 1;
        tick();
        d_axi_arready = 0;
        d_axi_rvalid = 1; d_axi_rdata = c0; d_axi_rresp = 2'b00; d_axi_rlast = 0;
        tick();
        d_axi_rdata = c1; d_axi_rresp = 2'b01;
        tick();
        d_axi_rdata = c2; d_axi_rresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rvalid", u_axi_rvalid, 1'b1);
            chk("bp_d_rready", d_axi_rready, 1'b0);
            chk("bp_rdata", u_axi_rdata, {c1, c0});
            chk("bp_rresp", u_axi_rresp, 2'b01);
            tick();
        end
        chk("bp_rlast0", u_axi_rlast, 1'b0);
        u_axi_rready = 1;
        tick();
        u_axi_rready = 0;
        #1;
        chk("bp_rvalid_clr", u_axi_rvalid, 1'b0);
        chk("bp_d_rready_rel", d_axi_rready, 1'b1);
        tick();
        d_axi_rdata = c3; d_axi_rresp = 2'b00; d_axi_rlast = 1;
        tick();
        d_axi_rvalid = 0; d_axi_rlast = 0;
        #1;
        chk("bp_rvalid2", u_axi_rvalid, 1'b1);
        chk("bp_rdata2", u_axi_rdata, {c3, c2});
        chk("bp_rresp2", u_axi_rresp, 2'b00);
        chk("bp_rlast2", u_axi_rlast, 1'b1);
        u_axi_rready = 1;
        tick();
        u_axi_rready = 0;

        // narrow read pass: 0x6008 size3 len0, unwritten lane reads 0
        u_axi_araddr = 32'h6008; u_axi_arsize = 3'd3; u_axi_arlen = 8'd0; u_axi_arburst = 2'b01;
        u_axi_arvalid = 1;
        tick();
        u_axi_arvalid = 0;
        #1;
        chk("rp_d_arsize", d_axi_arsize, 3'd3);
        chk("rp_d_arlen", d_axi_arlen, 8'd0);
        d_axi_arready = 1;
        tick();
        d_axi_arready = 0;
        d_axi_rvalid = 1; d_axi_rdata = e0; d_axi_rresp = 2'b00; d_axi_rlast = 1;
        tick();
        d_axi_rvalid = 0; d_axi_rlast = 0;
        #1;
        chk("rp_rdata", u_axi_rdata, {e0, 64'h0});
        chk("rp_rlast", u_axi_rlast, 1'b1);
        u_axi_rready = 1;
        tick();
        u_axi_rready = 0;

        // reset mid-burst: 0x7000 size4 len0, reset after first d_w beat
        u_axi_awaddr = 32'h7000; u_axi_awsize = 3'd4; u_axi_awlen = 8'd0; u_axi_awburst = 2'b01;
        u_axi_awvalid = 1;
        tick();
        u_axi_awvalid = 0;
        #1 chk("rm_d_awlen", d_axi_awlen, 8'd1);
        d_axi_awready = 1;
        tick();
        d_axi_awready = 0;
        u_axi_wdata = d0; u_axi_wstrb = 16'hFFFF; u_axi_wlast = 1; u_axi_wvalid = 1; d_axi_wready = 1;
        #1;
        chk("rm_d_wvalid", d_axi_wvalid, 1'b1);
        chk("rm_u_wready", u_axi_wready, 1'b0);
        tick();
        areset = 1; d_axi_bvalid = 1; u_axi_bready = 1;
        tick();
        chk("rm_d_wvalid_rst", d_axi_wvalid, 1'b0);
        chk("rm_d_awvalid_rst", d_axi_awvalid, 1'b0);
        chk("rm_bvalid_rst", u_axi_bvalid, 1'b0);
        chk("rm_d_bready_rst", d_axi_bready, 1'b0);
        chk("rm_awready_rst", u_axi_awready, 1'b0);
        chk("rm_arready_rst", u_axi_arready, 1'b0);
        chk("rm_rvalid_rst", u_axi_rvalid, 1'b0);
        chk("rm_d_rready_rst", d_axi_rready, 1'b0);
        areset = 0; u_axi_wvalid = 0; u_axi_wlast = 0; d_axi_wready = 0;
        tick();
        chk("rm_awready_rel", u_axi_awready, 1'b1);
        chk("rm_bvalid_rel", u_axi_bvalid, 1'b0);
        d_axi_bvalid = 0; u_axi_bready = 0;
        u_axi_awaddr = 32'h8000; u_axi_awsize = 3'd3; u_axi_awlen = 8'd0; u_axi_awburst = 2'b01;
        u_axi_awvalid = 1;
        tick();
        u_axi_awvalid = 0;
        #1;
        chk("rm_d_awaddr", d_axi_awaddr, 32'h8000);
        chk("rm_d_awsize", d_axi_awsize, 3'd3);
        chk("rm_d_awlen", d_axi_awlen, 8'd0);
        d_axi_awready = 1;
        tick();
        d_axi_awready = 0;
        u_axi_wdata = d1; u_axi_wstrb = 16'h00FF; u_axi_wlast = 1; u_axi_wvalid = 1; d_axi_wready = 1;
        #1;
        chk("rm_d_wdata", d_axi_wdata, 64'h1716151413121110);
        chk("rm_d_wstrb", d_axi_wstrb, 8'hFF);
        chk("rm_d_wlast", d_axi_wlast, 1'b1);
        chk("rm_u_wready2", u_axi_wready, 1'b1);
        tick();
        u_axi_wvalid = 0; u_axi_wlast = 0; d_axi_wready = 0;
        d_axi_bvalid = 1; d_axi_bresp = 2'b00; u_axi_bready = 1;
        #1 chk("rm_bvalid2", u_axi_bvalid, 1'b1);
        tick();
        d_axi_bvalid = 0; u_axi_bready = 0;
        #1 chk("rm_awready_end", u_axi_awready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
